// File: rtl/rggen_bit_field_w_fifo_if.sv
// Software-side bit field access bundle: one access strobe with read/write masks.
// The register block drives it through "master"; the bit field answers through "slave"/"bit_field".
interface rggen_bit_field_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] read_mask;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output valid, read_mask, write_mask, write_data,
    input  read_data, value
  );

  modport slave (
    input  valid, read_mask, write_mask, write_data,
    output read_data, value
  );

  modport bit_field (
    input  valid, read_mask, write_mask, write_data,
    output read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_w_fifo.sv
// Write-queue bit field: each software write is merged into a shadow value and
// queued; hardware drains the queue with valid/ready. Writes into a full queue set a sticky overflow.
module rggen_bit_field_w_fifo #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter int               DEPTH         = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  rggen_bit_field_if.bit_field       bit_field_if,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_overflow,
  input  logic                       i_overflow_clear
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] merged;
  logic             write, pop, push, drop, empty, full;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign write  = bit_field_if.valid && (bit_field_if.write_mask != '0);
  assign merged = (shadow_q & ~bit_field_if.write_mask)
                | (bit_field_if.write_data & bit_field_if.write_mask);
  assign pop    = !empty && i_ready;
  assign push   = write && (!full || pop);
  assign drop   = write && full && !pop;

  always_comb begin
    shadow_d   = shadow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      shadow_d = merged;
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end else if (i_overflow_clear) begin
      overflow_d = 1'b0;
    end

    // Head is registered; when the entry being written becomes the new head
    // (empty queue, or the last entry popped this cycle) take it from the write path.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      data_d = merged;
    end else begin
      data_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_q   <= INITIAL_VALUE;
      data_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      data_q     <= data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= merged;
    end
  end

  assign bit_field_if.read_data = shadow_q & bit_field_if.read_mask;
  assign bit_field_if.value     = shadow_q;

  assign o_valid    = !empty;
  assign o_full     = full;
  assign o_count    = count_q;
  assign o_data     = data_q;
  assign o_overflow = overflow_q;
endmodule
